// File: rtl/ne_fp_ffp_m_align_pkg.sv
// rtl/ne_fp_ffp_m_align_pkg.sv - shared parameters, types and helpers for the mantissa alignment stage
// Contents: lane/width parameters, op_mode bit indices, align_t signed lane type,
//           mode decode and sign application helpers.
package ne_fp_align_pkg;

    localparam int LANES = 16;
    localparam int AMW   = 22;
    localparam int BMW   = 8;
    localparam int AW    = 26;
    localparam int SW    = 6;

    localparam int OPM_TEST = 3;
    localparam int OPM_TF32 = 2;
    localparam int OPM_FP8  = 1;
    localparam int OPM_INT  = 0;

    typedef logic signed [AW:0] align_t;

    typedef enum logic [2:0] {
        M_NONE,
        M_INT,
        M_FP8,
        M_TF32,
        M_TEST
    } mode_e;

    // Anything that is not exactly one-hot collapses to M_NONE (all lanes zero).
    function automatic mode_e decode_mode(input logic [3:0] op);
        mode_e m;
        m = M_NONE;
        if ($onehot(op)) begin
            if (op[OPM_TF32])      m = M_TF32;
            else if (op[OPM_FP8])  m = M_FP8;
            else if (op[OPM_INT])  m = M_INT;
            else                   m = M_TEST;
        end
        return m;
    endfunction

    // Zero magnitude yields +0 because two's complement of zero is zero.
    function automatic align_t apply_sign(input logic s, input logic [AW-1:0] mag);
        align_t v;
        v = {1'b0, mag};
        return s ? -v : v;
    endfunction

endpackage

// File: rtl/ne_fp_ffp_m_align_if.sv
// rtl/ne_fp_ffp_m_align_if.sv - beat interface between exponent-align stage, mantissa align and adder tree
// Modports: slave  = alignment stage (consumes in_* lane fields, produces out_* / aligned lanes)
//           master = upstream driver / downstream observer
interface ne_fp_ffp_m_align_if;
    import ne_fp_align_pkg::*;

    logic                       in_vld;
    logic [3:0]                 op_mode;
    logic [8:0]                 e_max;
    logic [LANES*SW-1:0]        a_e_sub;
    logic [LANES*SW-1:0]        b_e_sub;
    logic [LANES-1:0]           a_e_overflow;
    logic [LANES-1:0]           b_e_overflow;
    logic [LANES-1:0]           a_s;
    logic [LANES-1:0]           b_s;
    logic [LANES*AMW-1:0]       a_m;
    logic [LANES*BMW-1:0]       b_m;

    logic                       out_vld;
    logic [3:0]                 out_op_mode;
    logic [8:0]                 out_e_max;
    logic [LANES*(AW+1)-1:0]    a_m_align;
    logic [LANES*(AW+1)-1:0]    b_m_align;
    logic [LANES-1:0]           a_sticky;
    logic [LANES-1:0]           b_sticky;

    modport slave (
        input  in_vld, op_mode, e_max, a_e_sub, b_e_sub, a_e_overflow, b_e_overflow,
               a_s, b_s, a_m, b_m,
        output out_vld, out_op_mode, out_e_max, a_m_align, b_m_align, a_sticky, b_sticky
    );

    modport master (
        output in_vld, op_mode, e_max, a_e_sub, b_e_sub, a_e_overflow, b_e_overflow,
               a_s, b_s, a_m, b_m,
        input  out_vld, out_op_mode, out_e_max, a_m_align, b_m_align, a_sticky, b_sticky
    );

endinterface

// File: rtl/ne_fp_ffp_m_align_rshift_lane.sv
// rtl/ne_fp_ffp_m_align_rshift_lane.sv - one AW-bit right shifter with overflow zeroing and sticky
// Ports: field (AW) magnitude to shift, sh (SW) shift amount, ovf force-zero,
//        mag (AW) shifted magnitude, sticky (only with NE_M_ALIGN_STICKY_EN) OR of bits lost.
module ne_m_rshift_lane
    import ne_fp_align_pkg::*;
(
    input  logic [AW-1:0] field,
    input  logic [SW-1:0] sh,
    input  logic          ovf,
    output logic [AW-1:0] mag
`ifdef NE_M_ALIGN_STICKY_EN
    ,
    output logic          sticky
`endif
);

    logic kill;

    // Shifting by AW or more leaves nothing, same as an upstream overflow.
    assign kill = ovf || (sh >= SW'(AW));
    assign mag  = kill ? '0 : (field >> sh);

`ifdef NE_M_ALIGN_STICKY_EN
    logic [AW-1:0] lost_mask;

    assign lost_mask = (AW'(1) << sh) - AW'(1);
    assign sticky    = kill ? (|field) : (|(field & lost_mask));
`endif

endmodule

// File: rtl/ne_fp_ffp_m_align.sv
// rtl/ne_fp_ffp_m_align.sv - mantissa alignment stage: per-lane right shift and two's complement, 2-cycle pipe
// Ports: clk, rst (sync, active high), bus (ne_fp_ffp_m_align_if.slave) carrying the input beat
//        and the aligned output beat. Optional sticky outputs enabled by NE_M_ALIGN_STICKY_EN.
module ne_fp_ffp_m_align
    import ne_fp_align_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ne_fp_ffp_m_align_if.slave    bus
);

    localparam int AL = AW + 1;

    mode_e mode;
    assign mode = decode_mode(bus.op_mode);

    logic [AW-1:0] a_field [LANES];
    logic [AW-1:0] b_field [LANES];
    logic [SW-1:0] a_sh    [LANES];
    logic [SW-1:0] b_sh    [LANES];
    logic          a_ov    [LANES];
    logic          b_ov    [LANES];
    logic [AW-1:0] a_mag   [LANES];
    logic [AW-1:0] b_mag   [LANES];

    // Magnitude field construction: mantissas are left-justified into AW bits
    // so a shift amount of 0 means "already at e_max".
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_field[i] = '0;
            b_field[i] = '0;
            a_sh[i]    = '0;
            b_sh[i]    = '0;
            a_ov[i]    = 1'b0;
            b_ov[i]    = 1'b0;
            case (mode)
                M_TF32: begin
                    a_field[i] = {bus.a_m[i*AMW +: AMW], {(AW-AMW){1'b0}}};
                    a_sh[i]    = bus.a_e_sub[i*SW +: SW];
                    a_ov[i]    = bus.a_e_overflow[i];
                end
                M_FP8: begin
                    a_field[i] = {bus.a_m[i*AMW +: BMW], {(AW-BMW){1'b0}}};
                    b_field[i] = {bus.b_m[i*BMW +: BMW], {(AW-BMW){1'b0}}};
                    a_sh[i]    = bus.a_e_sub[i*SW +: SW];
                    b_sh[i]    = bus.b_e_sub[i*SW +: SW];
                    a_ov[i]    = bus.a_e_overflow[i];
                    b_ov[i]    = bus.b_e_overflow[i];
                end
                M_TEST: begin
                    // FP8 layout with the shifter bypassed.
                    a_field[i] = {bus.a_m[i*AMW +: BMW], {(AW-BMW){1'b0}}};
                    b_field[i] = {bus.b_m[i*BMW +: BMW], {(AW-BMW){1'b0}}};
                end
                M_INT: begin
                    a_field[i] = {{(AW-AMW){1'b0}}, bus.a_m[i*AMW +: AMW]};
                end
                default: ;
            endcase
        end
    end

`ifdef NE_M_ALIGN_STICKY_EN
    logic a_stk [LANES];
    logic b_stk [LANES];
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ne_m_rshift_lane u_a (
            .field  (a_field[i]),
            .sh     (a_sh[i]),
            .ovf    (a_ov[i]),
            .mag    (a_mag[i])
`ifdef NE_M_ALIGN_STICKY_EN
            ,
            .sticky (a_stk[i])
`endif
        );
        ne_m_rshift_lane u_b (
            .field  (b_field[i]),
            .sh     (b_sh[i]),
            .ovf    (b_ov[i]),
            .mag    (b_mag[i])
`ifdef NE_M_ALIGN_STICKY_EN
            ,
            .sticky (b_stk[i])
`endif
        );
    end

    logic                 s1_vld;
    logic [3:0]           s1_op;
    logic [8:0]           s1_em;
    logic [AW-1:0]        s1_a_mag [LANES];
    logic [AW-1:0]        s1_b_mag [LANES];
    logic [LANES-1:0]     s1_a_sgn;
    logic [LANES-1:0]     s1_b_sgn;

    logic                 out_vld_r;
    logic [3:0]           out_op_r;
    logic [8:0]           out_em_r;
    logic [LANES*AL-1:0]  a_align_r;
    logic [LANES*AL-1:0]  b_align_r;

    // Stage registers only load on a valid beat so idle cycles hold the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_op     <= '0;
            s1_em     <= '0;
            s1_a_sgn  <= '0;
            s1_b_sgn  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_a_mag[i] <= '0;
                s1_b_mag[i] <= '0;
            end
            out_vld_r <= 1'b0;
            out_op_r  <= '0;
            out_em_r  <= '0;
            a_align_r <= '0;
            b_align_r <= '0;
        end else begin
            s1_vld    <= bus.in_vld;
            out_vld_r <= s1_vld;
            if (bus.in_vld) begin
                s1_op    <= bus.op_mode;
                s1_em    <= bus.e_max;
                s1_a_sgn <= bus.a_s;
                s1_b_sgn <= bus.b_s;
                for (int i = 0; i < LANES; i++) begin
                    s1_a_mag[i] <= a_mag[i];
                    s1_b_mag[i] <= b_mag[i];
                end
            end
            if (s1_vld) begin
                out_op_r <= s1_op;
                out_em_r <= s1_em;
                for (int i = 0; i < LANES; i++) begin
                    a_align_r[i*AL +: AL] <= apply_sign(s1_a_sgn[i], s1_a_mag[i]);
                    b_align_r[i*AL +: AL] <= apply_sign(s1_b_sgn[i], s1_b_mag[i]);
                end
            end
        end
    end

    assign bus.out_vld     = out_vld_r;
    assign bus.out_op_mode = out_op_r;
    assign bus.out_e_max   = out_em_r;
    assign bus.a_m_align   = a_align_r;
    assign bus.b_m_align   = b_align_r;

`ifdef NE_M_ALIGN_STICKY_EN
    logic [LANES-1:0] s1_a_stk;
    logic [LANES-1:0] s1_b_stk;
    logic [LANES-1:0] a_stk_r;
    logic [LANES-1:0] b_stk_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_stk <= '0;
            s1_b_stk <= '0;
            a_stk_r  <= '0;
            b_stk_r  <= '0;
        end else begin
            if (bus.in_vld) begin
                for (int i = 0; i < LANES; i++) begin
                    s1_a_stk[i] <= a_stk[i];
                    s1_b_stk[i] <= b_stk[i];
                end
            end
            if (s1_vld) begin
                a_stk_r <= s1_a_stk;
                b_stk_r <= s1_b_stk;
            end
        end
    end

    assign bus.a_sticky = a_stk_r;
    assign bus.b_sticky = b_stk_r;
`else
    assign bus.a_sticky = '0;
    assign bus.b_sticky = '0;
`endif

endmodule
